sfu_drain: RTL and testbench
============================

// Module: sfu_drain
// PURPOSE
//  Consumer end of the SFU row output stream. Captures each valid col*bw output word from the SFU row,
//  buffers it in a small FIFO, and writes it to the output SRAM at base_addr+nij (active-low CEN/WEN).
//  Sits between the SFU row and the psum/output SRAM port. Pulses done after nij_len words are written.
// PARAMETERS
//  col      8    lanes per word
//  bw       4    bits per lane (signed two's complement)
//  nij_len  36   output words per tile
//  addr_w   11   SRAM address width
//  depth    4    FIFO entries (power of 2, >=2)
//  relu     0    1: clamp negative lanes to 0 on capture
// PORTS
//  clk        in   1          clock
//  reset      in   1          synchronous, active-high
//  start      in   1          begin tile; honoured only in IDLE
//  base_addr  in   addr_w     first SRAM address, latched on accepted start
//  in         in   col*bw     SFU row word, lane j at [j*bw +: bw]
//  i_valid    in   1          in is valid this cycle
//  grant      in   1          SRAM port available for a write this cycle
//  sram_cen   out  1          chip enable, active low, registered
//  sram_wen   out  1          write enable, active low, registered
//  sram_addr  out  addr_w     write address, registered
//  sram_d     out  col*bw     write data, registered
//  busy       out  1          high in COLLECT
//  done       out  1          one-cycle pulse at tile completion
//  overflow   out  1          sticky: word dropped (FIFO full) or excess word; cleared on accepted start
// BEHAVIOUR
//  Reset: state=IDLE, FIFO empty, counters 0, sram_cen=1, sram_wen=1, sram_addr=0, sram_d=0,
//   busy=0, done=0, overflow=0. Reset mid-tile discards FIFO contents and pending writes.
//  FSM: IDLE -start-> COLLECT (latch base_addr, clear rd_cnt/wr_cnt/overflow);
//   COLLECT -(wr_cnt==nij_len-1 and write issued)-> DONE; DONE -> IDLE unconditionally (done=1 in DONE).
//  start in COLLECT/DONE ignored. i_valid in IDLE/DONE ignored (not an overflow).
//  Push (COLLECT): i_valid && rd_cnt<nij_len && (!full || pop) -> enqueue, rd_cnt++.
//   i_valid && full && !pop -> word dropped, overflow=1, rd_cnt unchanged.
//   i_valid && rd_cnt==nij_len -> word dropped, overflow=1.
//  Pop: COLLECT && !empty && grant -> on that edge register sram_cen=0, sram_wen=0,
//   sram_addr=base_addr+wr_cnt (mod 2^addr_w, wraps), sram_d=head; wr_cnt++. Otherwise cen=wen=1,
//   addr/d hold previous values.
//  Simultaneous push+pop legal at any occupancy incl. full; occupancy unchanged.
//  Latency: i_valid at edge E0 with empty FIFO and grant high -> write cycle (cen=0) follows edge E1.
//  grant low stalls writes only; capture continues until FIFO full.
//  relu=1: lane with MSB=1 stored as 0; else lanes stored unmodified. No width change.
//  Counters width $clog2(nij_len+1); FIFO pointers $clog2(depth)+1 bits (full/empty by MSB compare).
//  done asserted exactly one cycle, the cycle after the final write cycle; busy low during done.
// STRUCTURE
//  Shared package (sfu_pkg): state enum {IDLE,COLLECT,DONE}, lane typedef logic signed [bw-1:0],
//   word typedef logic [col-1:0][bw-1:0].
//  One sub-module: sync_fifo (depth, width=col*bw; push/pop/full/empty/head, push-when-full rejected
//   unless same-cycle pop). FSM, counters, relu and SRAM register stage in sfu_drain.
// TESTING
//  1 Reset, start base_addr=0x010, 36 back-to-back i_valid, grant=1 -> 36 writes at 0x010..0x033
//    in input order, cen first low 2 cycles after first i_valid, done pulses once, overflow=0.
//  2 grant=0 for 10 cycles during burst, depth=4 -> words 5..n dropped until space, overflow=1,
//    written words are exactly the accepted ones in order.
//  3 Alternate grant 1/0 with i_valid every other cycle -> full/push+pop at full occupancy, no loss, 36 writes.
//  4 relu=1, lanes {-8,-1,0,7} -> stored {0,0,0,7}; relu=0 -> unchanged.
//  5 base_addr=0x7F0, addr_w=11 -> addresses wrap 0x7FF->0x000 after 16 writes.
//  6 Reset asserted after 20 writes -> next cycle cen=wen=1, busy=0; new start writes from base again;
//    start during COLLECT and 37th i_valid -> ignored / overflow=1 respectively.

Source files
------------

// File: rtl/sfu_pkg.sv
// Shared types for the SFU output drain: FSM state encoding and lane/word shapes.
package sfu_pkg;
    localparam int COL = 8;
    localparam int BW  = 4;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    typedef logic signed [BW-1:0]   lane_t;
    typedef logic [COL-1:0][BW-1:0] word_t;
endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO; a push while full is taken only if a pop happens the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end
endmodule

// File: rtl/sfu_drain.sv
// Drains the SFU row output stream through a FIFO into the output SRAM at base_addr+n.
module sfu_drain
    import sfu_pkg::*;
#(
    parameter int col     = 8,
    parameter int bw      = 4,
    parameter int nij_len = 36,
    parameter int addr_w  = 11,
    parameter int depth   = 4,
    parameter int relu    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_addr,
    input  logic [col*bw-1:0] in,
    input  logic              i_valid,
    input  logic              grant,
    output logic              sram_cen,
    output logic              sram_wen,
    output logic [addr_w-1:0] sram_addr,
    output logic [col*bw-1:0] sram_d,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    localparam int CW = $clog2(nij_len + 1);

    state_t                  state_q;
    logic [CW-1:0]           rd_cnt_q, wr_cnt_q;
    logic [addr_w-1:0]       base_q, sram_addr_q;
    logic [col*bw-1:0]       sram_d_q, fifo_head;
    logic                    sram_cen_q, sram_wen_q, busy_q, done_q, overflow_q;
    logic [col-1:0][bw-1:0]  in_w, cap_w;
    logic                    fifo_full, fifo_empty;
    logic                    collecting, room, push, pop, drop, last_wr;

    assign in_w = in;

    always_comb begin
        cap_w = in_w;
        for (int j = 0; j < col; j++) begin
            if (relu != 0 && in_w[j][bw-1]) cap_w[j] = '0;
        end
    end

    assign collecting = (state_q == COLLECT);
    assign room       = (rd_cnt_q < CW'(nij_len));
    assign pop        = collecting && !fifo_empty && grant;
    assign push       = collecting && i_valid && room && (!fifo_full || pop);
    assign drop       = collecting && i_valid && (!room || (fifo_full && !pop));
    assign last_wr    = pop && (wr_cnt_q == CW'(nij_len - 1));

    sync_fifo #(.DEPTH(depth), .WIDTH(col*bw)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (cap_w),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            base_q      <= '0;
            sram_cen_q  <= 1'b1;
            sram_wen_q  <= 1'b1;
            sram_addr_q <= '0;
            sram_d_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            sram_cen_q <= 1'b1;
            sram_wen_q <= 1'b1;
            if (pop) begin
                sram_cen_q  <= 1'b0;
                sram_wen_q  <= 1'b0;
                sram_addr_q <= base_q + addr_w'(wr_cnt_q);
                sram_d_q    <= fifo_head;
                wr_cnt_q    <= wr_cnt_q + 1'b1;
            end
            if (push) rd_cnt_q   <= rd_cnt_q + 1'b1;
            if (drop) overflow_q <= 1'b1;
            // done lands one cycle after the last write cycle, when the FSM is back in IDLE.
            unique case (state_q)
                IDLE: if (start) begin
                    state_q    <= COLLECT;
                    busy_q     <= 1'b1;
                    base_q     <= base_addr;
                    rd_cnt_q   <= '0;
                    wr_cnt_q   <= '0;
                    overflow_q <= 1'b0;
                end
                COLLECT: if (last_wr) begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                end
                DONE: begin
                    state_q <= IDLE;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sram_cen  = sram_cen_q;
    assign sram_wen  = sram_wen_q;
    assign sram_addr = sram_addr_q;
    assign sram_d    = sram_d_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overflow  = overflow_q;
endmodule

// File: tb/tb_sfu_drain.sv
// Directed bench for sfu_drain: a relu=0 and a relu=1 instance share stimulus; writes are logged per instance.
module tb_sfu_drain;
    logic        clk = 1'b0;
    logic        reset, start, i_valid, grant;
    logic [10:0] base_addr;
    logic [31:0] din;

    logic        cen0, wen0, busy0, done0, ovf0;
    logic [10:0] addr0;
    logic [31:0] d0;
    logic        cen1, wen1, busy1, done1, ovf1;
    logic [10:0] addr1;
    logic [31:0] d1;

    sfu_drain #(.relu(0)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .in(din),
        .i_valid(i_valid), .grant(grant), .sram_cen(cen0), .sram_wen(wen0),
        .sram_addr(addr0), .sram_d(d0), .busy(busy0), .done(done0), .overflow(ovf0));

    sfu_drain #(.relu(1)) dut_r (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .in(din),
        .i_valid(i_valid), .grant(grant), .sram_cen(cen1), .sram_wen(wen1),
        .sram_addr(addr1), .sram_d(d1), .busy(busy1), .done(done1), .overflow(ovf1));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [10:0] la[$];
    logic [31:0] ld[$];
    logic [31:0] lr[$];
    int          lcyc[$];
    int          done_cnt, done_cyc, bad_busy, bad_wen;
    int          pass_cnt = 0, total = 0;

    always @(negedge clk) begin
        if (!cen0) begin
            la.push_back(addr0);
            ld.push_back(d0);
            lcyc.push_back(cyc);
            if (wen0) bad_wen++;
        end
        if (!cen1) lr.push_back(d1);
        if (done0) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy0) bad_busy++;
        end
    end

    typedef struct {
        logic [31:0] in_w;
        logic [31:0] exp_relu;
    } relu_vec_t;

    function automatic logic [31:0] pat(input int k);
        return 32'(k) * 32'h0135_7BDF + 32'h2468_ACE1;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        la.delete(); ld.delete(); lr.delete(); lcyc.delete();
        done_cnt = 0; done_cyc = 0; bad_busy = 0; bad_wen = 0;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; i_valid = 1'b0; grant = 1'b1; base_addr = '0; din = '0;
        tick(); tick();
        reset = 1'b0;
        clear_logs();
    endtask

    task automatic do_start(input logic [10:0] b);
        start = 1'b1; base_addr = b;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [31:0] w, input logic g);
        i_valid = 1'b1; din = w; grant = g;
        tick();
        i_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        grant = 1'b1;
        while (done_cnt == 0 && n < 300) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(done_cnt), 64'd1);
        tick();
    endtask

    relu_vec_t rv[6];
    int        first;

    initial begin
        rv[0] = '{32'h70F8_70F8, 32'h7000_7000};
        rv[1] = '{32'h1234_5678, 32'h1234_5670};
        rv[2] = '{32'hFFFF_FFFF, 32'h0000_0000};
        rv[3] = '{32'h7777_7777, 32'h7777_7777};
        rv[4] = '{32'h89AB_CDEF, 32'h0000_0000};
        rv[5] = '{32'h1E2D_3C4B, 32'h1020_3040};

        // 1: reset values, straight burst, latency and done timing
        do_reset();
        chk("rst_cen", 64'(cen0), 64'd1);
        chk("rst_wen", 64'(wen0), 64'd1);
        chk("rst_addr", 64'(addr0), 64'd0);
        chk("rst_d", 64'(d0), 64'd0);
        chk("rst_busy", 64'(busy0), 64'd0);
        chk("rst_done", 64'(done0), 64'd0);
        chk("rst_ovf", 64'(ovf0), 64'd0);
        do_start(11'h010);
        chk("t1_busy", 64'(busy0), 64'd1);
        first = cyc;
        for (int k = 0; k < 36; k++) send(pat(k), 1'b1);
        wait_done();
        chk("t1_count", 64'(la.size()), 64'd36);
        for (int i = 0; i < 36 && i < la.size(); i++) begin
            chk("t1_addr", 64'(la[i]), 64'(11'h010 + 11'(i)));
            chk("t1_data", 64'(ld[i]), 64'(pat(i)));
        end
        if (lcyc.size() == 36) begin
            chk("t1_latency", 64'(lcyc[0] - first), 64'd2);
            chk("t1_done_cyc", 64'(done_cyc), 64'(lcyc[35] + 1));
        end
        chk("t1_done_once", 64'(done_cnt), 64'd1);
        chk("t1_busy_in_done", 64'(bad_busy), 64'd0);
        chk("t1_wen", 64'(bad_wen), 64'd0);
        chk("t1_ovf", 64'(ovf0), 64'd0);
        chk("t1_busy_end", 64'(busy0), 64'd0);

        // 2: grant stalls 10 cycles, words 4..9 dropped
        do_reset();
        do_start(11'h000);
        for (int k = 0; k < 10; k++) send(pat(k), 1'b0);
        for (int k = 10; k < 42; k++) send(pat(k), 1'b1);
        wait_done();
        chk("t2_count", 64'(la.size()), 64'd36);
        for (int i = 0; i < 36 && i < ld.size(); i++)
            chk("t2_data", 64'(ld[i]), 64'(pat(i < 4 ? i : i + 6)));
        chk("t2_ovf", 64'(ovf0), 64'd1);

        // 3: fill, then push+pop at full occupancy with alternating grant
        do_reset();
        do_start(11'h040);
        for (int k = 0; k < 4; k++) send(pat(k), 1'b0);
        for (int k = 4; k < 36; k++) begin
            send(pat(k), 1'b1);
            grant = 1'b0;
            tick();
        end
        wait_done();
        chk("t3_count", 64'(la.size()), 64'd36);
        for (int i = 0; i < 36 && i < la.size(); i++) begin
            chk("t3_addr", 64'(la[i]), 64'(11'h040 + 11'(i)));
            chk("t3_data", 64'(ld[i]), 64'(pat(i)));
        end
        chk("t3_ovf", 64'(ovf0), 64'd0);

        // 4: relu clamp vs passthrough
        do_reset();
        do_start(11'h000);
        for (int k = 0; k < 6; k++) send(rv[k].in_w, 1'b1);
        for (int k = 6; k < 36; k++) send(pat(k), 1'b1);
        wait_done();
        chk("t4_count_r", 64'(lr.size()), 64'd36);
        for (int i = 0; i < 6 && i < lr.size() && i < ld.size(); i++) begin
            chk("t4_relu", 64'(lr[i]), 64'(rv[i].exp_relu));
            chk("t4_plain", 64'(ld[i]), 64'(rv[i].in_w));
        end

        // 5: address wrap
        do_reset();
        do_start(11'h7F0);
        for (int k = 0; k < 36; k++) send(pat(k), 1'b1);
        wait_done();
        chk("t5_count", 64'(la.size()), 64'd36);
        if (la.size() == 36) begin
            chk("t5_addr15", 64'(la[15]), 64'h7FF);
            chk("t5_addr16", 64'(la[16]), 64'h000);
            chk("t5_addr35", 64'(la[35]), 64'h013);
        end

        // 6: reset mid-tile, restart, ignored start, excess word
        do_reset();
        do_start(11'h100);
        begin
            int k = 0;
            while (la.size() < 20 && k < 36) begin
                send(pat(k), 1'b1);
                k++;
            end
        end
        chk("t6_mid_writes", 64'(la.size()), 64'd20);
        reset = 1'b1;
        tick();
        chk("t6_rst_cen", 64'(cen0), 64'd1);
        chk("t6_rst_wen", 64'(wen0), 64'd1);
        chk("t6_rst_busy", 64'(busy0), 64'd0);
        reset = 1'b0;
        clear_logs();
        do_start(11'h200);
        for (int k = 0; k < 37; k++) begin
            if (k == 5) begin
                start = 1'b1;
                base_addr = 11'h300;
            end
            send(pat(k + 100), 1'b1);
            start = 1'b0;
        end
        wait_done();
        chk("t6_count", 64'(la.size()), 64'd36);
        for (int i = 0; i < 36 && i < la.size(); i++) begin
            chk("t6_addr", 64'(la[i]), 64'(11'h200 + 11'(i)));
            chk("t6_data", 64'(ld[i]), 64'(pat(i + 100)));
        end
        chk("t6_ovf", 64'(ovf0), 64'd1);
        chk("t6_done_once", 64'(done_cnt), 64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
